// File: rtl/joy_pkg.sv
// Shared definitions for the two-joystick 74HC165 serial reader.
package joy_pkg;

  // Bit positions inside one joystick byte (1 = pressed).
  localparam int JOY_UP    = 7;
  localparam int JOY_DOWN  = 6;
  localparam int JOY_LEFT  = 5;
  localparam int JOY_RIGHT = 4;
  localparam int JOY_FIRE1 = 3;
  localparam int JOY_FIRE2 = 2;
  localparam int JOY_FIRE3 = 1;
  localparam int JOY_START = 0;

  // One scan of the chain carries both joysticks.
  localparam int JOY_FRAME_BITS = 16;

  // Reader FSM encoding.
  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_UPDATE   = 3'd3,
    ST_GAP      = 3'd4
  } joy_state_e;

  // Map a raw frame (raw[k] = k-th bit shifted in, already active-high)
  // to {joy1, joy2}. Bit k lands on position 15-k, which gives
  // joy1[7-k] for k = 0..7 and joy2[15-k] for k = 8..15.
  function automatic logic [JOY_FRAME_BITS-1:0] frame_to_joy(
    input logic [JOY_FRAME_BITS-1:0] raw
  );
    logic [JOY_FRAME_BITS-1:0] res;
    res = {JOY_FRAME_BITS{1'b0}};
    for (int k = 0; k < JOY_FRAME_BITS; k++) begin
      res[JOY_FRAME_BITS-1-k] = raw[k];
    end
    return res;
  endfunction

endpackage

// File: rtl/joy_phase_timer.sv
// Loadable down-counter with terminal-count flag; times every FSM phase.
module joy_phase_timer #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count_r;

  // Reload on every phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= INIT;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/joy_shift_reader.sv
// Serial reader for the two-joystick 74HC165 chain with optional
// two-frame debounce and per-scan / on-change strobes.
module joy_shift_reader
  import joy_pkg::*;
#(
  parameter int CLKDIV   = 4,
  parameter int SCAN_GAP = 64,
  parameter int DEBOUNCE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       joy_data,
  output logic       joy_load_n,
  output logic       joy_clk,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic       scan_done,
  output logic       changed
);

  localparam int TMAX = (CLKDIV > SCAN_GAP) ? CLKDIV : SCAN_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] CLKDIV_LD = TW'(CLKDIV - 1);
  localparam logic [TW-1:0] GAP_LD    = TW'(SCAN_GAP - 1);
  localparam logic          DB_EN     = (DEBOUNCE != 0);

  joy_state_e                state_r;
  logic [3:0]                bit_r;
  logic [JOY_FRAME_BITS-1:0] raw_r;
  logic [JOY_FRAME_BITS-1:0] prev_r;
  logic [JOY_FRAME_BITS-1:0] joy_r;
  logic [JOY_FRAME_BITS-1:0] new_joy_s;
  logic                      joy_load_n_r;
  logic                      joy_clk_r;
  logic                      scan_done_r;
  logic                      changed_r;
  logic                      accept_s;
  logic                      timer_load_s;
  logic [TW-1:0]             timer_value_s;
  logic                      timer_tc_s;

  joy_phase_timer #(
    .WIDTH (TW),
    .INIT  (CLKDIV_LD)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .tc         (timer_tc_s)
  );

  // A frame is accepted when debounce is off or it repeats the previous one.
  assign accept_s  = !DB_EN || (raw_r == prev_r);
  assign new_joy_s = frame_to_joy(raw_r);

  // Reload the phase timer on each state entry with that state's length.
  always_comb begin
    timer_load_s  = 1'b0;
    timer_value_s = CLKDIV_LD;
    case (state_r)
      ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_GAP: begin
        timer_load_s  = timer_tc_s;
        timer_value_s = CLKDIV_LD;
      end
      ST_UPDATE: begin
        timer_load_s  = 1'b1;
        timer_value_s = GAP_LD;
      end
      default: begin
        timer_load_s  = 1'b1;
        timer_value_s = CLKDIV_LD;
      end
    endcase
  end

  // Scan FSM: sequencing, bit capture, debounce/update and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_LOAD;
      bit_r        <= 4'd0;
      raw_r        <= {JOY_FRAME_BITS{1'b0}};
      prev_r       <= {JOY_FRAME_BITS{1'b0}};
      joy_r        <= {JOY_FRAME_BITS{1'b0}};
      joy_load_n_r <= 1'b1;
      joy_clk_r    <= 1'b0;
      scan_done_r  <= 1'b0;
      changed_r    <= 1'b0;
    end else begin
      // Chain strobes follow the current state one cycle later.
      joy_load_n_r <= (state_r != ST_LOAD);
      joy_clk_r    <= (state_r == ST_SHIFT_HI);
      scan_done_r  <= 1'b0;
      changed_r    <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (timer_tc_s) begin
            state_r <= ST_SHIFT_LO;
            bit_r   <= 4'd0;
          end
        end
        ST_SHIFT_LO: begin
          if (timer_tc_s) begin
            raw_r[bit_r] <= ~joy_data;
            if (bit_r == 4'd15) begin
              state_r <= ST_UPDATE;
            end else begin
              state_r <= ST_SHIFT_HI;
            end
          end
        end
        ST_SHIFT_HI: begin
          if (timer_tc_s) begin
            bit_r   <= bit_r + 4'd1;
            state_r <= ST_SHIFT_LO;
          end
        end
        ST_UPDATE: begin
          scan_done_r <= 1'b1;
          prev_r      <= raw_r;
          if (accept_s) begin
            joy_r     <= new_joy_s;
            changed_r <= (new_joy_s != joy_r);
          end
          state_r <= ST_GAP;
        end
        ST_GAP: begin
          if (timer_tc_s) begin
            state_r <= ST_LOAD;
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

  assign joy_load_n = joy_load_n_r;
  assign joy_clk    = joy_clk_r;
  assign joy1       = joy_r[15:8];
  assign joy2       = joy_r[7:0];
  assign scan_done  = scan_done_r;
  assign changed    = changed_r;

endmodule

// File: tb/tb_joy_shift_reader.sv
// Directed bench for joy_shift_reader: three instances (default,
// no-debounce, fast timing), each fed by a behavioural 74HC165 chain.
module tb_joy_shift_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults. B: DEBOUNCE=0. C: CLKDIV=1, SCAN_GAP=1.
  logic rst_a, rst_b, rst_c;
  logic data_a, data_b, data_c;
  logic load_a, load_b, load_c;
  logic jclk_a, jclk_b, jclk_c;
  logic [7:0] j1_a, j2_a, j1_b, j2_b, j1_c, j2_c;
  logic done_a, done_b, done_c;
  logic chg_a, chg_b, chg_c;
  logic [15:0] pat_a = 16'hFFFF, pat_b = 16'hFFFF, pat_c = 16'hFFFF;
  logic [15:0] sr_a = 16'hFFFF, sr_b = 16'hFFFF, sr_c = 16'hFFFF;

  joy_shift_reader u_dut (
    .clk(clk), .rst_n(rst_a), .joy_data(data_a), .joy_load_n(load_a),
    .joy_clk(jclk_a), .joy1(j1_a), .joy2(j2_a), .scan_done(done_a), .changed(chg_a));

  joy_shift_reader #(.DEBOUNCE(0)) u_nodb (
    .clk(clk), .rst_n(rst_b), .joy_data(data_b), .joy_load_n(load_b),
    .joy_clk(jclk_b), .joy1(j1_b), .joy2(j2_b), .scan_done(done_b), .changed(chg_b));

  joy_shift_reader #(.CLKDIV(1), .SCAN_GAP(1)) u_fast (
    .clk(clk), .rst_n(rst_c), .joy_data(data_c), .joy_load_n(load_c),
    .joy_clk(jclk_c), .joy1(j1_c), .joy2(j2_c), .scan_done(done_c), .changed(chg_c));

  // Chain models: parallel load while load_n low, shift on joy_clk rise.
  // Serial bit k is pat[15-k], so {joy1,joy2} must equal ~pat.
  always @(posedge jclk_a or negedge load_a)
    if (!load_a) sr_a <= pat_a; else sr_a <= {sr_a[14:0], 1'b1};
  always @(posedge jclk_b or negedge load_b)
    if (!load_b) sr_b <= pat_b; else sr_b <= {sr_b[14:0], 1'b1};
  always @(posedge jclk_c or negedge load_c)
    if (!load_c) sr_c <= pat_c; else sr_c <= {sr_c[14:0], 1'b1};
  assign data_a = sr_a[15];
  assign data_b = sr_b[15];
  assign data_c = sr_c[15];

  // Waits for scan_done of one instance; cycles counts negedges consumed.
  task automatic wait_done(input int which, input int limit, output int cycles, output bit hit);
    cycles = 0;
    hit = 1'b0;
    while (!hit && cycles < limit) begin
      @(negedge clk);
      cycles++;
      case (which)
        0: hit = done_a;
        1: hit = done_b;
        default: hit = done_c;
      endcase
    end
  endtask

  task automatic test_reset();
    int load_first, load_cnt, load2_first, load2_cnt, pulses, bad_run;
    int hi_run, lo_run, done_cnt, done1, done2, chg_cnt, nonzero;
    logic prev_clk;
    load_first = 0; load_cnt = 0; load2_first = 0; load2_cnt = 0; pulses = 0;
    bad_run = 0; hi_run = 0; lo_run = 0; done_cnt = 0; done1 = 0; done2 = 0;
    chg_cnt = 0; nonzero = 0; prev_clk = 1'b0;
    pat_a = 16'hFFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (load_a !== 1'b1 || jclk_a !== 1'b0 || j1_a !== 8'h00 || j2_a !== 8'h00 ||
        done_a !== 1'b0 || chg_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got load_n=%b clk=%b joy1=%h joy2=%h done=%b chg=%b expected 1 0 00 00 0 0",
               load_a, jclk_a, j1_a, j2_a, done_a, chg_a);
    end
    rst_a = 1'b1;
    for (int c = 1; c <= 330; c++) begin
      @(negedge clk);
      if (!load_a) begin
        if (c <= 8) begin
          load_cnt++;
          if (load_first == 0) load_first = c;
        end else if (c >= 190 && c <= 200) begin
          load2_cnt++;
          if (load2_first == 0) load2_first = c;
        end
      end
      if (c <= 129) begin
        if (jclk_a) begin
          if (!prev_clk) begin
            pulses++;
            if (pulses > 1 && lo_run != 4) bad_run++;
          end
          hi_run++;
          lo_run = 0;
        end else begin
          if (prev_clk && hi_run != 4) bad_run++;
          lo_run++;
          hi_run = 0;
        end
        prev_clk = jclk_a;
      end
      if (done_a) begin
        done_cnt++;
        if (done_cnt == 1) done1 = c; else done2 = c;
      end
      if (chg_a) chg_cnt++;
      if (j1_a !== 8'h00 || j2_a !== 8'h00) nonzero++;
    end
    checks++;
    if (load_first != 1 || load_cnt != 4) begin
      errors++;
      $display("FAIL load_pulse: got first=%0d len=%0d expected first=1 len=4", load_first, load_cnt);
    end
    checks++;
    if (load2_first != 194 || load2_cnt != 4) begin
      errors++;
      $display("FAIL load_pulse2: got first=%0d len=%0d expected first=194 len=4", load2_first, load2_cnt);
    end
    checks++;
    if (pulses != 15 || bad_run != 0) begin
      errors++;
      $display("FAIL clk_pulses: got pulses=%0d bad_runs=%0d expected 15 and 0", pulses, bad_run);
    end
    checks++;
    if (done_cnt != 2 || done1 != 129 || done2 != 322) begin
      errors++;
      $display("FAIL scan_period: got count=%0d at %0d,%0d expected 2 at 129,322", done_cnt, done1, done2);
    end
    checks++;
    if (chg_cnt != 0 || nonzero != 0) begin
      errors++;
      $display("FAIL idle_outputs: got changed=%0d nonzero=%0d expected 0 and 0", chg_cnt, nonzero);
    end
  endtask

  task automatic test_debounce_press();
    int n;
    bit hit;
    pat_a = 16'h77FF;
    wait_done(0, 400, n, hit);
    checks++;
    if (!hit || j1_a !== 8'h00 || chg_a !== 1'b0) begin
      errors++;
      $display("FAIL db_first_scan: got hit=%b joy1=%h chg=%b expected 1 00 0", hit, j1_a, chg_a);
    end
    wait_done(0, 400, n, hit);
    checks++;
    if (!hit || j1_a !== 8'h88 || j2_a !== 8'h00 || chg_a !== 1'b1) begin
      errors++;
      $display("FAIL db_second_scan: got hit=%b joy1=%h joy2=%h chg=%b expected 1 88 00 1", hit, j1_a, j2_a, chg_a);
    end
    @(negedge clk);
    checks++;
    if (chg_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: got chg=%b done=%b expected 0 0", chg_a, done_a);
    end
    wait_done(0, 400, n, hit);
    checks++;
    if (!hit || n != 192 || chg_a !== 1'b0 || j1_a !== 8'h88) begin
      errors++;
      $display("FAIL db_third_scan: got hit=%b gap=%0d chg=%b joy1=%h expected 1 192 0 88", hit, n, chg_a, j1_a);
    end
  endtask

  task automatic test_glitch();
    int n;
    bit hit;
    pat_a = 16'h77FE;
    wait_done(0, 400, n, hit);
    checks++;
    if (!hit || j2_a !== 8'h00 || chg_a !== 1'b0 || j1_a !== 8'h88) begin
      errors++;
      $display("FAIL glitch_scan: got hit=%b joy1=%h joy2=%h chg=%b expected 1 88 00 0", hit, j1_a, j2_a, chg_a);
    end
    pat_a = 16'h77FF;
    for (int s = 0; s < 2; s++) begin
      wait_done(0, 400, n, hit);
      checks++;
      if (!hit || j2_a !== 8'h00 || chg_a !== 1'b0) begin
        errors++;
        $display("FAIL glitch_after%0d: got hit=%b joy2=%h chg=%b expected 1 00 0", s, hit, j2_a, chg_a);
      end
    end
  endtask

  task automatic test_mid_scan_reset();
    int n;
    bit hit;
    n = 0;
    while (load_a !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (load_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_sync: got load_n=%b expected 0 within 400 cycles", load_a);
    end
    repeat (65) @(negedge clk);
    checks++;
    if (jclk_a !== 1'b1 || j1_a !== 8'h88) begin
      errors++;
      $display("FAIL mid_pre_reset: got clk=%b joy1=%h expected 1 88", jclk_a, j1_a);
    end
    rst_a = 1'b0;
    @(negedge clk);
    checks++;
    if (jclk_a !== 1'b0 || load_a !== 1'b1 || j1_a !== 8'h00 || j2_a !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got clk=%b load_n=%b joy1=%h joy2=%h expected 0 1 00 00", jclk_a, load_a, j1_a, j2_a);
    end
    rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if (load_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_new_load: got load_n=%b expected 0", load_a);
    end
    wait_done(0, 400, n, hit);
    checks++;
    if (!hit || n != 128 || j1_a !== 8'h00 || chg_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_full_scan: got hit=%b cycles=%0d joy1=%h chg=%b expected 1 128 00 0", hit, n, j1_a, chg_a);
    end
  endtask

  task automatic test_no_debounce();
    int n;
    bit hit;
    rst_b = 1'b1;
    wait_done(1, 300, n, hit);
    checks++;
    if (!hit || n != 129 || j1_b !== 8'h00 || j2_b !== 8'h10 || chg_b !== 1'b1) begin
      errors++;
      $display("FAIL nodb_first: got hit=%b cycles=%0d joy1=%h joy2=%h chg=%b expected 1 129 00 10 1",
               hit, n, j1_b, j2_b, chg_b);
    end
    wait_done(1, 300, n, hit);
    checks++;
    if (!hit || j2_b !== 8'h10 || chg_b !== 1'b0) begin
      errors++;
      $display("FAIL nodb_second: got hit=%b joy2=%h chg=%b expected 1 10 0", hit, j2_b, chg_b);
    end
  endtask

  task automatic test_fast();
    int n;
    bit hit;
    rst_c = 1'b1;
    wait_done(2, 100, n, hit);
    checks++;
    if (!hit || n != 33 || j1_c !== 8'h00 || chg_c !== 1'b0) begin
      errors++;
      $display("FAIL fast_first: got hit=%b cycles=%0d joy1=%h chg=%b expected 1 33 00 0", hit, n, j1_c, chg_c);
    end
    wait_done(2, 100, n, hit);
    checks++;
    if (!hit || n != 34 || j1_c !== 8'h5A || j2_c !== 8'h3C || chg_c !== 1'b1) begin
      errors++;
      $display("FAIL fast_second: got hit=%b period=%0d joy1=%h joy2=%h chg=%b expected 1 34 5a 3c 1",
               hit, n, j1_c, j2_c, chg_c);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    pat_b = 16'hFFEF;
    pat_c = 16'hA5C3;
    test_reset();
    test_debounce_press();
    test_glitch();
    test_mid_scan_reset();
    test_no_debounce();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
